// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, owner encoding, default memory latency, counter width.
package mem_arb_pkg;

  // Read latency of the shared memory when the instantiator does not override it.
  localparam int MEM_LAT_DEFAULT = 1;

  // Wide enough for the largest legal latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction fetch and data stage for one memory access.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only samples owner when it actually grants.
// Ports: if_req, dm_req (requests), last_owner (previous grantee), owner (winner).
// Build option MEM_ARB_RR_EN: ties alternate away from last_owner; otherwise dm wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_owner,
  output logic owner
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority never looks at history.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    owner = OWN_IF;
    if (dm_req && !if_req) begin
      owner = OWN_DM;
    end else if (dm_req && if_req) begin
`ifdef MEM_ARB_RR_EN
      owner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
`else
      owner = OWN_DM;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (if_*) and data stage (dm_*).
// Latency: request-to-ack MEM_LAT+1 cycles; one access every MEM_LAT+2 cycles.
// Backpressure: losing/waiting requester sees its stall high until its ack pulse.
// Ports: clk, rst (async, active-high); if_req/if_addr -> if_rdata/if_ack;
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack; mem_en/mem_we/mem_addr/mem_wd,
//   mem_rd to the shared memory; if_stall/dm_stall to the pipeline.
// Build option MEM_ARB_RR_EN: alternating tie-break using a last_owner register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              if_stall,
  output logic              dm_stall
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              pick_owner;
  logic              last_owner;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .owner      (pick_owner)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    mem_en = 1'b0;
    mem_we = 1'b0;
    if_ack = 1'b0;
    dm_ack = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          // Everything the access needs is latched here, so requester
          // changes after the grant cannot disturb it.
          owner_d = pick_owner;
          addr_d  = (pick_owner == OWN_DM) ? dm_addr : if_addr;
          we_d    = (pick_owner == OWN_DM) && dm_we;
          wdata_d = (pick_owner == OWN_DM) ? dm_wdata : '0;
          cnt_d   = CNT_START;
          state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_owner_d = pick_owner;
`endif
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        // The counter still holds its start value only in the first cycle,
        // so a store is issued exactly once however long the access lasts.
        mem_we = we_q && (cnt_q == CNT_START);
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_DM) dm_rdata_d = mem_rd;
            else                   if_rdata_d = mem_rd;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if_ack  = (owner_q == OWN_IF);
        dm_ack  = (owner_q == OWN_DM);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= OWN_IF;
    else     last_owner_q <= last_owner_d;
  end
`endif

  assign mem_addr = addr_q;
  assign mem_wd   = wdata_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with MEM_LAT=1 (a_*) and one with MEM_LAT=3 (b_*),
// each behind a small memory model; completions are checked against a scoreboard.
module tb_mem_arbiter;

  logic        clk, rst;

  logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic        a_mem_en, a_mem_we, a_if_stall, a_dm_stall;
  logic [31:0] a_mem_addr, a_mem_wd, a_mem_rd;

  logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_we, b_if_stall, b_dm_stall;
  logic [31:0] b_mem_addr, b_mem_wd, b_mem_rd;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  int   b_we_seen = 0;
  int   t0;

  mem_arbiter #(.DATA_W(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd),
    .mem_rd(a_mem_rd), .if_stall(a_if_stall), .dm_stall(a_dm_stall)
  );

  mem_arbiter #(.DATA_W(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd),
    .mem_rd(b_mem_rd), .if_stall(b_if_stall), .dm_stall(b_dm_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents before any store: a fixed pattern per address.
  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h8C080004;
    return {8'hA5, a, ~a, a};
  endfunction

  logic [31:0] store_a [256];
  bit          wr_a    [256];
  logic [31:0] store_b [256];
  bit          wr_b    [256];

  assign a_mem_rd = wr_a[a_mem_addr[7:0]] ? store_a[a_mem_addr[7:0]] : init_word(a_mem_addr[7:0]);
  assign b_mem_rd = wr_b[b_mem_addr[7:0]] ? store_b[b_mem_addr[7:0]] : init_word(b_mem_addr[7:0]);

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) begin
      store_a[a_mem_addr[7:0]] <= a_mem_wd;
      wr_a[a_mem_addr[7:0]]    <= 1'b1;
    end
    if (b_mem_en && b_mem_we) begin
      store_b[b_mem_addr[7:0]] <= b_mem_wd;
      wr_b[b_mem_addr[7:0]]    <= 1'b1;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_n++;
  endtask

  // Let combinational outputs settle, then retire any completion against the scoreboard.
  task automatic settle();
    exp_t e;
    #1;
    if (b_mem_we) b_we_seen++;
    check1("a_ack_onehot", a_if_ack & a_dm_ack, 1'b0);
    check1("b_ack_onehot", b_if_ack & b_dm_ack, 1'b0);
    if (a_if_ack || a_dm_ack) begin
      check1("a_ack_expected", qa.size() != 0, 1'b1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check1("a_ack_owner", a_dm_ack, e.is_dm);
        check32("a_ack_cycle", 32'(cyc_n), 32'(e.cyc));
        check32("a_rdata", e.is_dm ? a_dm_rdata : a_if_rdata, e.rdata);
      end
    end
    if (b_if_ack || b_dm_ack) begin
      check1("b_ack_expected", qb.size() != 0, 1'b1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check1("b_ack_owner", b_dm_ack, e.is_dm);
        check32("b_ack_cycle", 32'(cyc_n), 32'(e.cyc));
        check32("b_rdata", e.is_dm ? b_dm_rdata : b_if_rdata, e.rdata);
      end
    end
  endtask

  task automatic clear_inputs();
    a_if_req = 0; a_if_addr = '0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    clear_inputs();
    qa.delete();
    qb.delete();
    settle();
    tick();
    settle();
    rst = 1'b0;
  endtask

  task automatic run_b_dm(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      settle();
      if (b_dm_ack) begin
        b_dm_req = 0;
        b_dm_we  = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset state: everything observable is zero while rst is held.
    tick();
    rst = 1'b1;
    #1;
    check1("rst_a_mem_en", a_mem_en, 1'b0);
    check1("rst_a_mem_we", a_mem_we, 1'b0);
    check1("rst_a_if_ack", a_if_ack, 1'b0);
    check1("rst_a_dm_ack", a_dm_ack, 1'b0);
    check32("rst_a_if_rdata", a_if_rdata, 32'h0);
    check32("rst_a_dm_rdata", a_dm_rdata, 32'h0);
    check32("rst_a_mem_addr", a_mem_addr, 32'h0);
    check1("rst_b_mem_en", b_mem_en, 1'b0);
    check32("rst_b_dm_rdata", b_dm_rdata, 32'h0);
    check1("rst_a_if_stall", a_if_stall, 1'b0);

    // Single fetch, MEM_LAT=1.
    do_reset();
    tick();
    t0 = cyc_n;
    a_if_req  = 1;
    a_if_addr = 32'h10;
    qa.push_back('{is_dm: 1'b0, rdata: 32'h8C080004, cyc: t0 + 2});
    settle();
    check1("fetch_c0_mem_en", a_mem_en, 1'b0);
    check1("fetch_c0_if_stall", a_if_stall, 1'b1);
    tick();
    settle();
    check1("fetch_c1_mem_en", a_mem_en, 1'b1);
    check1("fetch_c1_mem_we", a_mem_we, 1'b0);
    check32("fetch_c1_mem_addr", a_mem_addr, 32'h10);
    tick();
    settle();
    check1("fetch_c2_if_ack", a_if_ack, 1'b1);
    check1("fetch_c2_if_stall", a_if_stall, 1'b0);
    a_if_req = 0;
    tick();
    settle();
    check1("fetch_c3_if_ack", a_if_ack, 1'b0);
    check1("fetch_c3_mem_en", a_mem_en, 1'b0);

    // Simultaneous fetch and load: dm first, fetch stalls through cycle 4.
    do_reset();
    tick();
    t0 = cyc_n;
    a_if_req  = 1;
    a_if_addr = 32'h10;
    a_dm_req  = 1;
    a_dm_we   = 0;
    a_dm_addr = 32'h40;
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h40), cyc: t0 + 2});
    qa.push_back('{is_dm: 1'b0, rdata: 32'h8C080004, cyc: t0 + 5});
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      settle();
      check1($sformatf("both_if_stall_c%0d", c), a_if_stall, c <= 4);
      check1($sformatf("both_dm_stall_c%0d", c), a_dm_stall, c <= 1);
      if (a_dm_ack) a_dm_req = 0;
      if (a_if_ack) a_if_req = 0;
    end
    check32("both_queue_drained", 32'(qa.size()), 32'd0);

    // Load withdrawn one cycle after grant still completes; later field changes ignored.
    do_reset();
    tick();
    t0 = cyc_n;
    a_dm_req  = 1;
    a_dm_addr = 32'h44;
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h44), cyc: t0 + 2});
    settle();
    tick();
    a_dm_req  = 0;
    a_dm_addr = 32'h99;
    settle();
    check32("withdraw_mem_addr", a_mem_addr, 32'h44);
    tick();
    settle();
    check1("withdraw_dm_ack", a_dm_ack, 1'b1);
    tick();
    settle();
    check1("withdraw_ack_pulse", a_dm_ack, 1'b0);

    // Three back-to-back ties with both requesters always asking.
    do_reset();
    tick();
    t0 = cyc_n;
    a_if_req  = 1;
    a_if_addr = 32'h50;
    a_dm_req  = 1;
    a_dm_addr = 32'h60;
`ifdef MEM_ARB_RR_EN
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h60), cyc: t0 + 2});
    qa.push_back('{is_dm: 1'b0, rdata: init_word(8'h50), cyc: t0 + 5});
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h60), cyc: t0 + 8});
`else
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h60), cyc: t0 + 2});
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h60), cyc: t0 + 5});
    qa.push_back('{is_dm: 1'b1, rdata: init_word(8'h60), cyc: t0 + 8});
`endif
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      settle();
    end
    a_if_req = 0;
    a_dm_req = 0;
    tick();
    settle();
    check32("ties_queue_drained", 32'(qa.size()), 32'd0);

    // MEM_LAT=3: load to set dm_rdata, then a store that must leave it alone.
    do_reset();
    tick();
    t0 = cyc_n;
    b_dm_req  = 1;
    b_dm_addr = 32'h24;
    qb.push_back('{is_dm: 1'b1, rdata: init_word(8'h24), cyc: t0 + 4});
    settle();
    run_b_dm(4);
    tick();
    t0 = cyc_n;
    b_we_seen  = 0;
    b_dm_req   = 1;
    b_dm_we    = 1;
    b_dm_addr  = 32'h20;
    b_dm_wdata = 32'hDEADBEEF;
    qb.push_back('{is_dm: 1'b1, rdata: init_word(8'h24), cyc: t0 + 4});
    settle();
    tick();
    settle();
    check1("store_c1_mem_we", b_mem_we, 1'b1);
    check32("store_c1_mem_addr", b_mem_addr, 32'h20);
    check32("store_c1_mem_wd", b_mem_wd, 32'hDEADBEEF);
    run_b_dm(3);
    check32("store_we_pulses", 32'(b_we_seen), 32'd1);
    check32("store_dm_rdata_kept", b_dm_rdata, init_word(8'h24));
    tick();
    t0 = cyc_n;
    b_dm_req  = 1;
    b_dm_addr = 32'h20;
    qb.push_back('{is_dm: 1'b1, rdata: 32'hDEADBEEF, cyc: t0 + 4});
    settle();
    run_b_dm(4);
    check32("store_queue_drained", 32'(qb.size()), 32'd0);

    // Reset in the second ACCESS cycle aborts the fetch with no ack and no retry.
    do_reset();
    tick();
    b_if_req  = 1;
    b_if_addr = 32'h70;
    settle();
    tick();
    settle();
    check1("abort_c1_mem_en", b_mem_en, 1'b1);
    tick();
    settle();
    check1("abort_c2_mem_en", b_mem_en, 1'b1);
    rst      = 1'b1;
    b_if_req = 0;
    #1;
    check1("abort_mem_en_drop", b_mem_en, 1'b0);
    check1("abort_mem_we_drop", b_mem_we, 1'b0);
    check1("abort_if_ack", b_if_ack, 1'b0);
    tick();
    settle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      settle();
      check1($sformatf("abort_idle_mem_en_%0d", c), b_mem_en, 1'b0);
    end
    check32("abort_if_rdata", b_if_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
